// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types: response codes and the read-response buffer entry.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  // Register word width carried by a buffered read response.
  localparam int unsigned AXIL_DATA_W = 32;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] data;
    resp_t                  resp;
  } rd_entry_t;

endpackage

// File: rtl/axil_rd_fifo.sv
// Synchronous response FIFO of DEPTH entries (any DEPTH >= 2) with full, empty
// and count outputs; pointers wrap modulo DEPTH.
module axil_rd_fifo
  import axil_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  rd_entry_t                    i_push_data,
  input  logic                         i_pop,
  output rd_entry_t                    o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  rd_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: storage is deliberately not reset; an entry is only observed once
  // r_count says it was written, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/axil_rd_slave.sv
// AXI4-Lite read slave: one-cycle register-bank read, buffered in-order R channel.
// Optional macro AXIL_RD_DECERR_EN: out-of-range addresses answer DECERR with zero data.
module axil_rd_slave
  import axil_pkg::*;
#(
  parameter int unsigned C_AXI_DATA_WIDTH = AXIL_DATA_W,
  parameter int unsigned C_AXI_ADDR_WIDTH = 8,
  parameter int unsigned NUM_REGS         = 16,
  parameter int unsigned RESP_DEPTH       = 4
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_ARESET,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
  input  logic                          AXI_ARVALID,
  output logic                          AXI_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   AXI_RDATA,
  output logic [1:0]                    AXI_RRESP,
  output logic                          AXI_RVALID,
  input  logic                          AXI_RREADY,
  output logic                          reg_rd_en,
  output logic [$clog2(NUM_REGS)-1:0]   reg_rd_idx,
  input  logic [C_AXI_DATA_WIDTH-1:0]   reg_rd_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

  if (C_AXI_DATA_WIDTH != AXIL_DATA_W) begin : g_chk_data_width
    $error("C_AXI_DATA_WIDTH must equal axil_pkg::AXIL_DATA_W");
  end
  if (RESP_DEPTH < 2) begin : g_chk_depth
    $error("RESP_DEPTH must be at least 2");
  end

  logic             w_ar_accept;
  logic             w_in_range;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic [CNT_W:0]   w_committed;
  logic             w_addr_unused;
  rd_entry_t        w_push_entry;
  rd_entry_t        w_head;

  logic             r_inflight;
  logic             r_inflight_err;

`ifdef AXIL_RD_DECERR_EN
  assign w_in_range = ((AXI_ARADDR >> (IDX_W + 2)) == '0);
`else
  assign w_in_range = 1'b1;
`endif

  // Byte-lane and high address bits are intentionally ignored in some builds.
  assign w_addr_unused = ^AXI_ARADDR;

  // Reads already accepted but not yet returned: buffered plus the one in flight.
  assign w_committed = {1'b0, w_fifo_count} + (CNT_W + 1)'(r_inflight);
  assign AXI_ARREADY = !AXI_ARESET && !w_fifo_full &&
                       (w_committed < (CNT_W + 1)'(RESP_DEPTH));
  assign w_ar_accept = AXI_ARVALID && AXI_ARREADY;

  assign reg_rd_en  = w_ar_accept && w_in_range;
  assign reg_rd_idx = AXI_ARADDR[2 +: IDX_W];

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      r_inflight     <= 1'b0;
      r_inflight_err <= 1'b0;
    end else begin
      r_inflight     <= w_ar_accept;
      r_inflight_err <= w_ar_accept && !w_in_range;
    end
  end

  // NOTE: every field gets a default before the conditional override so this
  // block stays purely combinational with no inferred latch.
  always_comb begin
    w_push_entry.data = reg_rd_data;
    w_push_entry.resp = OKAY;
    if (r_inflight_err) begin
      w_push_entry.data = '0;
      w_push_entry.resp = DECERR;
    end
  end

  assign w_push = r_inflight;
  assign w_pop  = AXI_RVALID && AXI_RREADY;

  axil_rd_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk         (AXI_ACLK),
    .rst         (AXI_ARESET),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // Outputs are forced to zero when nothing valid is presented, so never X.
  assign AXI_RVALID = !AXI_ARESET && !w_fifo_empty;
  assign AXI_RDATA  = AXI_RVALID ? w_head.data : '0;
  assign AXI_RRESP  = AXI_RVALID ? w_head.resp : OKAY;

endmodule

// File: doc/axil_rd_slave.md
AXIL_RD_SLAVE -- requirements
Module: axil_rd_slave

Interface
REQ-001 The block SHALL have these parameters: C_AXI_DATA_WIDTH, default 32, RDATA and register word width; C_AXI_ADDR_WIDTH, default 8, ARADDR width; NUM_REGS, default 16, power-of-two register count; RESP_DEPTH, default 4, minimum 2, response buffer entries.
REQ-002 Clock: AXI_ACLK, input, 1 bit, single clock; all logic on its rising edge.
REQ-003 Reset: AXI_ARESET, input, 1 bit, synchronous, active-high.
REQ-004 AXI_ARADDR, input, C_AXI_ADDR_WIDTH bits, read byte address.
REQ-005 AXI_ARVALID / AXI_ARREADY, input / output, 1 bit each, AR handshake.
REQ-006 AXI_RDATA, output, C_AXI_DATA_WIDTH bits, read data.
REQ-007 AXI_RRESP, output, 2 bits, read response.
REQ-008 AXI_RVALID / AXI_RREADY, output / input, 1 bit each, R handshake.
REQ-009 reg_rd_en, output, 1 bit, register bank read strobe.
REQ-010 reg_rd_idx, output, $clog2(NUM_REGS) bits, word index.
REQ-011 reg_rd_data, input, C_AXI_DATA_WIDTH bits, valid exactly one cycle after reg_rd_en.

Function
REQ-012 AR accept SHALL occur when AXI_ARVALID and AXI_ARREADY are both high at a rising edge.
REQ-013 AXI_ARREADY SHALL be high iff (buffer occupancy + in-flight reads) < RESP_DEPTH; it SHALL have no combinational dependency on AXI_ARVALID or AXI_RREADY.
REQ-014 In an accept cycle, reg_rd_en SHALL be high combinationally and reg_rd_idx SHALL be ARADDR[2 +: $clog2(NUM_REGS)]; ARADDR[1:0] is ignored.
REQ-015 reg_rd_data SHALL be captured at the edge after the accept edge, together with its response code, into the response buffer.
REQ-016 Latency: AXI_RVALID SHALL rise in the second cycle after the accept cycle when the buffer was empty.
REQ-017 Responses SHALL be returned in AR acceptance order.
REQ-018 While AXI_RVALID is high and AXI_RREADY is low, AXI_RVALID, AXI_RDATA and AXI_RRESP SHALL hold stable.
REQ-019 AXI_RDATA and AXI_RRESP SHALL never be X while AXI_RVALID is high.
REQ-020 With AXI_RREADY held high and AXI_ARVALID held high, the block SHALL sustain one accept and one R beat per cycle.
REQ-021 Simultaneous buffer push and pop SHALL leave occupancy unchanged; a pop when empty and a push when full SHALL never occur (guaranteed by REQ-013).
REQ-022 Buffer pointers SHALL wrap modulo RESP_DEPTH.

Reset
REQ-023 While AXI_ARESET is high: AXI_ARREADY=0, AXI_RVALID=0, AXI_RDATA=0, AXI_RRESP=2'b00, reg_rd_en=0; occupancy, in-flight count and pointers cleared.
REQ-024 The first cycle after AXI_ARESET deasserts SHALL have AXI_ARREADY=1 and AXI_RVALID=0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight and buffered responses; none SHALL appear after reset.

Configuration
REQ-026 With AXIL_RD_DECERR_EN defined, an address with ARADDR >= NUM_REGS*4 SHALL return RRESP=2'b11 (DECERR) and RDATA=0, and SHALL NOT assert reg_rd_en.
REQ-027 Without AXIL_RD_DECERR_EN, all addresses SHALL use the truncated index (wrap-around) and return RRESP=2'b00 (OKAY).

Structure
REQ-028 The shared package axil_pkg SHALL hold the resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and the buffer entry struct {data, resp}.
REQ-029 The response buffer SHALL be a sub-module axil_rd_fifo, a synchronous FIFO of RESP_DEPTH entries with full, empty and count outputs.

Verification
REQ-030 Single read: accept ARADDR=0x08 with reg[2]=0xDEADBEEF -> AXI_RVALID rises 2 cycles later with RDATA=0xDEADBEEF and RRESP=OKAY.
REQ-031 Backpressure: AXI_RREADY low for 3 cycles while AXI_RVALID is high -> RVALID, RDATA and RRESP are unchanged across all 3 cycles.
REQ-032 Streaming: 8 back-to-back reads to 0x00..0x1C with AXI_RREADY=1 -> 8 consecutive R beats returned in order, with no ARREADY gaps.
REQ-033 Full buffer: AXI_RREADY=0 and ARVALID held high -> exactly 4 accepts, then AXI_ARREADY=0; one RREADY pulse -> ARREADY returns high the next cycle.
REQ-034 Out-of-range: ARADDR=0x40 with the macro defined -> RRESP=DECERR, RDATA=0, no reg_rd_en; without the macro -> reg[0] returned with RRESP=OKAY.
REQ-035 Reset mid-stream: assert AXI_ARESET with 3 responses pending -> RVALID=0 the next cycle and no stale beats after release.
